// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with a start/busy/done
// handshake and per-operation signed/unsigned mode. Operates on magnitudes, negates at the end.
module seq_multiplier_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   product_q, product_d;
    logic            sign_q, sign_d;
    logic            done_q, done_d;

    logic [WIDTH-1:0] mag_a, mag_b;

    // The most-negative operand negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        mag_a = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        mag_b = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    end

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        sign_d    = sign_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                product_d = neg_q ? -acc_q : acc_q;
                // A zero product is never reported as negative.
                sign_d    = neg_q && (acc_q != '0);
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign sign    = sign_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param at WIDTH 8, 16 and 3: per-instance arithmetic model with a
// per-cycle compare, directed WIDTH=8 vectors with literal expectations, random 16/3-bit operations.
module tb_seq_multiplier_param;

    logic clk;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 16 : 3);

        logic           rst;
        logic           start;
        logic           sm;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] product;
        logic           sign;
        logic           busy;
        logic           done;
        bit             fin;

        seq_multiplier_param #(.WIDTH(W)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .signed_mode  (sm),
            .multiplicand (a),
            .multiplier   (b),
            .product      (product),
            .sign         (sign),
            .busy         (busy),
            .done         (done)
        );

        // Reference: an accepted operation finishes W+1 edges later with the plain integer product.
        function automatic longint ext(input logic [W-1:0] v, input logic s);
            return s ? longint'($signed(v)) : longint'(v);
        endfunction

        int             remaining;
        longint         pend_res;
        logic [2*W-1:0] exp_prod;
        logic           exp_sign;
        logic           exp_done;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                remaining <= 0;
                pend_res  <= 0;
                exp_prod  <= '0;
                exp_sign  <= 1'b0;
                exp_done  <= 1'b0;
            end else begin
                exp_done <= 1'b0;
                if (remaining == 0) begin
                    if (start) begin
                        pend_res  <= ext(a, sm) * ext(b, sm);
                        remaining <= W + 1;
                    end
                end else begin
                    remaining <= remaining - 1;
                    if (remaining == 1) begin
                        exp_prod <= pend_res[2*W-1:0];
                        exp_sign <= (pend_res < 0);
                        exp_done <= 1'b1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("w%0d product", W), longint'(product), longint'(exp_prod));
            check($sformatf("w%0d sign", W), longint'(sign), longint'(exp_sign));
            check($sformatf("w%0d busy", W), longint'(busy), longint'(remaining != 0));
            check($sformatf("w%0d done", W), longint'(done), longint'(exp_done));
        end

        if (gi > 0) begin : g_rand
            initial begin
                int lat;
                logic [W-1:0] mn;
                mn    = {1'b1, {(W-1){1'b0}}};
                fin   = 1'b0;
                rst   = 1'b0;
                start = 1'b0;
                sm    = 1'b0;
                a     = '0;
                b     = '0;
                #2 rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                for (int n = 0; n < 40; n++) begin
                    sm = 1'($urandom_range(0, 1));
                    if (n < 4) begin
                        a = n[0] ? {W{1'b1}} : mn;
                        b = n[1] ? {W{1'b1}} : mn;
                    end else begin
                        a = W'($urandom);
                        b = W'($urandom);
                    end
                    start = 1'b1;
                    lat   = -1;
                    do begin
                        @(negedge clk);
                        start = 1'b0;
                        lat++;
                    end while (!done && lat < W + 6);
                    check($sformatf("w%0d latency", W), longint'(lat), longint'(W + 1));
                    if (n[1:0] == 2'd3) begin
                        repeat ($urandom_range(1, 3)) @(negedge clk);
                    end
                end
                fin = 1'b1;
            end
        end
    end

    task automatic start8(input logic s, input logic [7:0] x, input logic [7:0] y);
        g_inst[0].sm    = s;
        g_inst[0].a     = x;
        g_inst[0].b     = y;
        g_inst[0].start = 1'b1;
    endtask

    // Counts edges after the start edge until done is seen; busy_n counts busy cycles.
    task automatic wait8(input bit keep, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        do begin
            @(negedge clk);
            if (!keep) g_inst[0].start = 1'b0;
            lat++;
            if (g_inst[0].busy) busy_n++;
        end while (!g_inst[0].done && lat < 20);
        if (!g_inst[0].done) check("w8 done timeout", 0, 1);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (g_inst[0].done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, cnt, waited;
        g_inst[0].rst   = 1'b0;
        g_inst[0].start = 1'b0;
        g_inst[0].sm    = 1'b0;
        g_inst[0].a     = '0;
        g_inst[0].b     = '0;
        #2 g_inst[0].rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset product", longint'(g_inst[0].product), 0);
        check("reset busy", longint'(g_inst[0].busy), 0);
        g_inst[0].rst = 1'b0;

        // 7 * -3 signed
        start8(1'b1, 8'd7, 8'hFD);
        wait8(1'b0, lat, busy_n);
        check("7*-3 latency", longint'(lat), 9);
        check("7*-3 busy cycles", longint'(busy_n), 9);
        check("7*-3 product", longint'(g_inst[0].product), 64'h0000_FFEB);
        check("7*-3 sign", longint'(g_inst[0].sign), 1);

        start8(1'b1, 8'h80, 8'h80);
        wait8(1'b0, lat, busy_n);
        check("-128*-128 product", longint'(g_inst[0].product), 64'h4000);
        check("-128*-128 sign", longint'(g_inst[0].sign), 0);

        start8(1'b1, 8'h80, 8'h7F);
        wait8(1'b0, lat, busy_n);
        check("-128*127 product", longint'(g_inst[0].product), 64'hC080);
        check("-128*127 sign", longint'(g_inst[0].sign), 1);

        start8(1'b0, 8'hFF, 8'hFF);
        wait8(1'b0, lat, busy_n);
        check("255*255 product", longint'(g_inst[0].product), 64'hFE01);
        check("255*255 sign", longint'(g_inst[0].sign), 0);

        start8(1'b1, 8'hFF, 8'hFF);
        wait8(1'b0, lat, busy_n);
        check("-1*-1 product", longint'(g_inst[0].product), 1);
        check("-1*-1 sign", longint'(g_inst[0].sign), 0);

        // -5 * 0 with an ignored restart attempt during RUN
        start8(1'b1, 8'hFB, 8'h00);
        @(negedge clk);
        g_inst[0].start = 1'b0;
        repeat (2) @(negedge clk);
        start8(1'b0, 8'd9, 8'd9);
        wait8(1'b0, lat, busy_n);
        check("-5*0 product", longint'(g_inst[0].product), 0);
        check("-5*0 sign", longint'(g_inst[0].sign), 0);
        count_dones(14, cnt);
        check("ignored start extra done", longint'(cnt), 0);

        // Reset in the fourth RUN cycle
        start8(1'b0, 8'd10, 8'd10);
        repeat (4) @(negedge clk);
        g_inst[0].start = 1'b0;
        g_inst[0].rst   = 1'b1;
        #1;
        check("abort busy", longint'(g_inst[0].busy), 0);
        check("abort product", longint'(g_inst[0].product), 0);
        check("abort sign", longint'(g_inst[0].sign), 0);
        check("abort done", longint'(g_inst[0].done), 0);
        @(negedge clk);
        g_inst[0].rst = 1'b0;
        count_dones(14, cnt);
        check("abort no done", longint'(cnt), 0);

        start8(1'b1, 8'd3, 8'd4);
        wait8(1'b0, lat, busy_n);
        check("3*4 latency", longint'(lat), 9);
        check("3*4 product", longint'(g_inst[0].product), 12);

        // Start during the done cycle: -6 * 5
        start8(1'b1, 8'hFA, 8'd5);
        wait8(1'b0, lat, busy_n);
        check("back-to-back gap", longint'(lat + 1), 10);
        check("-6*5 product", longint'(g_inst[0].product), 64'hFFE2);
        check("-6*5 sign", longint'(g_inst[0].sign), 1);

        // Start held high across done
        start8(1'b0, 8'd200, 8'd3);
        wait8(1'b1, lat, busy_n);
        check("200*3 product", longint'(g_inst[0].product), 64'h0258);
        @(negedge clk);
        check("held start done pulse", longint'(g_inst[0].done), 0);
        check("held start restarts", longint'(g_inst[0].busy), 1);
        g_inst[0].start = 1'b0;
        wait8(1'b0, lat, busy_n);
        check("held start 2nd latency", longint'(lat), 8);
        check("200*3 again product", longint'(g_inst[0].product), 64'h0258);

        waited = 0;
        while (!(g_inst[1].fin && g_inst[2].fin) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("random runs finished", longint'(g_inst[1].fin && g_inst[2].fin), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier with a start/busy/done handshake, signed or unsigned operand mode selected per operation, and a result register that holds until the next completion. It generalises the 8-bit signed multiplier in the arithmetic datapath to any operand width. It sits between the operand registers and the result consumer, one operation in flight at a time.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1: operands are two's complement; 0: unsigned; sampled with start
- multiplicand  input  WIDTH  operand A; sampled with start
- multiplier  input  WIDTH  operand B; sampled with start
- product  output  2*WIDTH  result (two's complement in signed mode); reset 0
- sign  output  1  result sign flag; reset 0
- busy  output  1  high while an operation is in progress; reset 0
- done  output  1  one-cycle completion pulse; reset 0

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: busy=0. When start=1 at a clock edge:
  - Capture operand magnitudes.
    - Signed mode: a negative operand is replaced by its two's complement. The most-negative value -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), held unsigned in WIDTH bits.
    - Unsigned mode: operands are captured as-is.
  - Capture the pending sign: signed mode uses multiplicand[MSB] XOR multiplier[MSB]; unsigned mode uses 0.
  - Clear the 2*WIDTH accumulator and clear the bit counter.
  - Go to RUN; busy=1.
- Internal registers:
  - 2*WIDTH multiplicand shift register: zero-extended magnitude, shifted left 1 per RUN cycle.
  - WIDTH multiplier shift register: shifted right 1 per RUN cycle.
  - Counter of ceil(log2(WIDTH+1)) bits.
- RUN, each edge:
  - If multiplier shift register bit 0 = 1, add the multiplicand shift register to the accumulator.
  - Shift both shift registers and increment the counter.
  - After WIDTH processed bits (counter = WIDTH-1 on this edge), go to FINISH.
- FINISH, one edge:
  - product <= pending sign ? -accumulator : accumulator (2*WIDTH two's complement).
  - sign <= pending sign, except sign=0 when the result is zero (e.g. -5*0 gives sign=0, product=0).
  - done=1 for exactly this following cycle; busy=0; go to IDLE.
- Width rules:
  - Accumulator never overflows 2*WIDTH: the maximum magnitude is (2^WIDTH-1)^2.
  - Signed results lie in [-2^(2W-2)+2^(W-1), 2^(2W-2)] and are always representable.
- start while busy=1 (RUN or FINISH) is ignored, including operand and mode changes; the in-flight operation is unaffected.
- product and sign are not cleared by start. They hold the last result until the next FINISH.
- rst asserted at any time, including mid-RUN: all outputs and internal registers go to 0 and state goes to IDLE immediately (asynchronous). The aborted operation produces no done.

## Timing
- Edge E0 samples start=1 in IDLE; busy is high from after E0.
- Edges E1..E(WIDTH) are the RUN cycles.
- Edge E(WIDTH+1) is FINISH: product and sign update; done=1 and busy=0 after this edge.
- Latency from start sample to done: WIDTH+1 cycles. For WIDTH=8, done is high in the 9th cycle after the start edge.
- Throughput: start may be asserted during the done cycle and is accepted at the next edge. Back-to-back operations therefore take WIDTH+2 cycles each.
- done is a single-cycle pulse even if start stays high. With start held high, a new operation begins at the edge ending the done cycle.
- Reset release: the first edge with rst=0 may accept start.

## Test plan
- WIDTH=8, signed, 7 * -3 -> done after 9 cycles; product=16'hFFEB (-21); sign=1; busy high for exactly 9 cycles.
- WIDTH=8, signed, -128 * -128 -> product=16'h4000 (16384), sign=0. Also -128 * 127 -> product=16'hC080 (-16256), sign=1.
- WIDTH=8, unsigned, 255 * 255 -> product=16'hFE01, sign=0. The same operands in signed mode (-1 * -1) -> product=1, sign=0.
- Signed -5 * 0 -> product=0, sign=0. Start pulsed with new operands mid-RUN -> ignored; the first result is unchanged and there is exactly one done.
- rst asserted at RUN cycle 4 -> all outputs 0 immediately and no done. A following 3*4 -> product=12 after 9 cycles. Start asserted in the done cycle -> accepted; second done 10 cycles after the first.
- WIDTH=16 and WIDTH=3: random signed/unsigned operands against a reference model. Check latency = WIDTH+1, and that the previous product holds until each new done.
